// File: rtl/cve2_irq_arbiter.sv
// cve2_irq_arbiter: fast-interrupt arbiter with edge/level channels, NMI latch, ack handshake and nesting stack
module cve2_irq_arbiter #(
    parameter int          NumIrqs   = 15,
    parameter int          IdWidth   = 5,
    parameter int          NestDepth = 2,
    parameter logic [31:0] EdgeMask  = 32'h0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NumIrqs-1:0] irq_i,
    input  logic [NumIrqs-1:0] irq_en_i,
    input  logic               global_ie_i,
    input  logic               irq_nm_i,
    input  logic               debug_mode_i,
    output logic               irq_req_o,
    output logic [IdWidth-1:0] irq_id_o,
    output logic               irq_nmi_o,
    input  logic               irq_ack_i,
    input  logic               irq_done_i,
    output logic [NumIrqs-1:0] pending_o,
    output logic [2:0]         active_depth_o,
    output logic               nmi_active_o
);
    typedef enum logic {S_IDLE, S_REQ} state_e;

    localparam logic [NumIrqs-1:0] EdgeSel = EdgeMask[NumIrqs-1:0];

    state_e             r_state;
    state_e             w_state_d;
    logic [IdWidth-1:0] r_id;
    logic [IdWidth-1:0] w_id_d;
    logic               r_is_nmi;
    logic               w_nmi_d;
    logic [NumIrqs-1:0] r_pending;
    logic [NumIrqs-1:0] r_prev;
    logic               r_nmi_prev;
    logic               r_nmi_latch;
    logic               r_nmi_active;
    logic [IdWidth-1:0] r_stack [NestDepth];
    logic [2:0]         r_depth;

    logic [NumIrqs-1:0] w_masked;
    logic [NumIrqs-1:0] w_clr;
    logic               w_found;
    logic [IdWidth-1:0] w_idx;
    logic [IdWidth-1:0] w_top;
    logic               w_still;
    logic               w_reg_ok;
    logic               w_nmi_ok;
    logic               w_push;
    logic               w_nmi_take;
    logic               w_pop;
    logic [2:0]         w_depth_pop;

    assign w_masked    = r_pending & irq_en_i & {NumIrqs{global_ie_i}};
    assign w_pop       = irq_done_i && !r_nmi_active && (r_depth != 3'd0);
    assign w_depth_pop = r_depth - {2'b0, w_pop};

    // Lowest-index enabled pending channel wins among regular lines.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = NumIrqs - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_found = 1'b1;
                w_idx   = IdWidth'(i);
            end
        end
    end

    // ID of the innermost active handler; only meaningful when the stack is non-empty.
    always_comb begin
        w_top = '0;
        for (int d = 0; d < NestDepth; d++) begin
            if (r_depth == 3'(d + 1)) w_top = r_stack[d];
        end
    end

    // Eligibility of the latched channel and the edge-pending clear on its acknowledge.
    always_comb begin
        w_still = 1'b0;
        w_clr   = '0;
        for (int i = 0; i < NumIrqs; i++) begin
            if (r_id == IdWidth'(i)) begin
                w_still  = w_masked[i];
                w_clr[i] = w_push;
            end
        end
    end

    // Only strictly higher priority may preempt, and never past a full stack or an active NMI.
    assign w_reg_ok = w_found && (r_depth < 3'(NestDepth)) && !r_nmi_active &&
                      ((r_depth == 3'd0) || (w_idx < w_top));
    assign w_nmi_ok = r_nmi_latch && !r_nmi_active;

    // Next-state and handshake decode: latch a candidate in IDLE, resolve ack or withdrawal in REQ.
    always_comb begin
        w_state_d  = r_state;
        w_id_d     = r_id;
        w_nmi_d    = r_is_nmi;
        w_push     = 1'b0;
        w_nmi_take = 1'b0;
        if (r_state == S_IDLE) begin
            if (!debug_mode_i && (w_nmi_ok || w_reg_ok)) begin
                w_state_d = S_REQ;
                w_nmi_d   = w_nmi_ok;
                w_id_d    = w_nmi_ok ? '0 : w_idx;
            end
        end else if (irq_ack_i) begin
            w_state_d  = S_IDLE;
            w_push     = !r_is_nmi;
            w_nmi_take = r_is_nmi;
        end else if (debug_mode_i || (!r_is_nmi && !w_still)) begin
            w_state_d = S_IDLE;
        end
    end

    // Request FSM state and the presented ID/NMI flag, held stable while in REQ.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_id     <= '0;
            r_is_nmi <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_id     <= w_id_d;
            r_is_nmi <= w_nmi_d;
        end
    end

    // Pending capture: level lines follow the input, edge lines set on rise and clear on ack (set wins).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending   <= '0;
            r_prev      <= '0;
            r_nmi_prev  <= 1'b0;
            r_nmi_latch <= 1'b0;
        end else begin
            r_pending   <= (irq_i & ~EdgeSel) |
                           (EdgeSel & ((irq_i & ~r_prev) | (r_pending & ~w_clr)));
            r_prev      <= irq_i;
            r_nmi_prev  <= irq_nm_i;
            r_nmi_latch <= (irq_nm_i && !r_nmi_prev) || (r_nmi_latch && !w_nmi_take);
        end
    end

    // Nesting stack and NMI-active flag: a same-cycle done is retired before the new entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_depth      <= 3'd0;
            r_nmi_active <= 1'b0;
            for (int d = 0; d < NestDepth; d++) r_stack[d] <= '0;
        end else begin
            r_depth      <= w_depth_pop + {2'b0, w_push};
            r_nmi_active <= (r_nmi_active && !irq_done_i) || w_nmi_take;
            for (int d = 0; d < NestDepth; d++) begin
                if (w_push && (w_depth_pop == 3'(d))) r_stack[d] <= r_id;
            end
        end
    end

    assign irq_req_o      = (r_state == S_REQ);
    assign irq_id_o       = irq_req_o ? r_id : '0;
    assign irq_nmi_o      = irq_req_o && r_is_nmi;
    assign pending_o      = r_pending;
    assign active_depth_o = r_depth;
    assign nmi_active_o   = r_nmi_active;
endmodule

// File: doc/cve2_irq_arbiter.md
Name: cve2_irq_arbiter

Overview:
- Parametrised fast-interrupt arbiter between the platform interrupt lines and the core controller.
- Generalises the fixed 15-line lowest-index-first fast-interrupt ID selection to NumIrqs channels.
- Adds per-channel edge/level mode, an NMI latch, a request/ack handshake and a bounded preemption (nesting) stack.
- Presents one interrupt at a time; the controller acknowledges trap entry and signals mret completion.

Parameters:
NumIrqs, 15, number of regular interrupt channels (1..32)
IdWidth, 5, width of irq_id_o; must be >= clog2(NumIrqs)
NestDepth, 2, maximum nested regular interrupts held active (1..4)
EdgeMask, 32'h0, bit i = 1: channel i is edge-triggered; 0: level-sensitive

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
irq_i  in  NumIrqs  raw interrupt lines, synchronous to clk_i
irq_en_i  in  NumIrqs  per-channel enable (mie fast bits)
global_ie_i  in  1  mstatus.MIE; masks regular channels only
irq_nm_i  in  1  non-maskable interrupt line
debug_mode_i  in  1  core in debug mode; suppresses all requests
irq_req_o  out  1  interrupt request to controller
irq_id_o  out  IdWidth  ID of the requested channel; 0 when irq_nmi_o = 1
irq_nmi_o  out  1  current request is the NMI
irq_ack_i  in  1  single-cycle pulse: controller took the trap for the presented request
irq_done_i  in  1  single-cycle pulse: mret retired
pending_o  out  NumIrqs  registered pending vector (mip mirror)
active_depth_o  out  3  number of regular interrupts on the nesting stack
nmi_active_o  out  1  NMI handler in progress

Behaviour:
- Reset values: pending 0, edge history 0, stack empty, active_depth_o 0, nmi_active_o 0, NMI latch 0, FSM IDLE, irq_req_o 0, irq_id_o 0, irq_nmi_o 0.
- Pending, level channel i: pending_q[i] <= irq_i[i] every cycle.
- Pending, edge channel i:
  - Set on a rising edge (irq_i & ~irq_prev_q).
  - Cleared on ack of ID i.
  - A set and a clear in the same cycle: set wins.
- NMI latch: set on a rising edge of irq_nm_i; cleared on ack while irq_nmi_o = 1.
- Candidate (combinational):
  - Valid when the NMI latch is set, or when the lowest index i with pending_q[i] & irq_en_i[i] & global_ie_i exists.
  - A regular candidate is valid only if the stack is not full, nmi_active is 0, and (stack empty or i < stack top ID). Equal or lower priority never preempts.
  - NMI beats any regular candidate; NMI is blocked only while nmi_active = 1.
  - debug_mode_i = 1 invalidates all candidates.
- FSM states:
  - IDLE: outputs low. A valid candidate latches its ID and NMI flag; next state REQ.
  - REQ: irq_req_o = 1; irq_id_o and irq_nmi_o hold the latched values, stable until exit.
    - irq_ack_i, regular request: push ID, clear edge pending, go to IDLE.
    - irq_ack_i, NMI request: set nmi_active, clear NMI latch, go to IDLE.
    - Latched regular ID no longer eligible (pending dropped, enable/global_ie cleared, debug entered) with no ack that cycle: withdraw to IDLE, irq_req_o low next cycle.
    - NMI request never withdraws except on debug_mode_i.
    - A higher-priority arrival during REQ does not replace the latched ID. It is presented after ack and return to IDLE, and then preempts.
- Latency: irq_i rise at cycle N; pending_q at N+1; irq_req_o at N+2.
- irq_done_i:
  - If nmi_active = 1, clears it.
  - Else pops the stack top.
  - With an empty stack and no NMI active, it is ignored; no underflow.
- ack and done in the same cycle: apply done first, then the push or NMI set.
- irq_ack_i outside REQ is ignored.
- Reset asserted mid-operation returns every register to its reset value asynchronously.

Test Plan:
- Level ch 3 with irq_en_i = 0x8 and global_ie_i = 1, pulse irq_i[3] at cycle 0 -> irq_req_o = 1 with irq_id_o = 3 at cycle 2; ack -> active_depth_o = 1; done -> active_depth_o = 0.
- Channels 5 and 2 assert simultaneously -> irq_id_o = 2 first; after ack, ch 5 is not requested (5 > 2); after done, ch 5 is requested.
- Nesting with NestDepth = 2: ack ch 7, then ch 4 preempts and is acked (depth 2); ch 1 asserts -> no request while full; one done -> ch 1 is requested.
- Edge ch 0 (EdgeMask = 1) with irq_i held high for 10 cycles -> exactly one request; pending_o[0] = 0 after ack; a second rising edge -> new request.
- NMI rising edge while ch 6 is active -> irq_nmi_o = 1 and irq_id_o = 0; after ack, nmi_active_o = 1 and regular requests are blocked; first done clears NMI, depth stays 1.
- Withdrawal: ch 3 in REQ, deassert irq_en_i[3] before ack -> irq_req_o = 0 next cycle. Separately: done with empty stack -> depth stays 0. Separately: rst_ni low in REQ -> all outputs 0 immediately.
